instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory interface that the CPU core reads through its PC.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU in reset until the image is fully loaded.

---
 rtl/instr_mem_loader_if.sv | 20 ++
 rtl/instr_mem_loader.sv | 152 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the instruction-memory loader.
// The slave modport is the loader. The master modport is the stream source and memory observer.
interface instr_mem_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        im_we_o;
  logic [31:0] im_addr_o;
  logic [31:0] im_data_o;

  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, im_we_o, im_addr_o, im_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, im_we_o, im_addr_o, im_data_o
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a header-prefixed big-endian byte stream into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  instr_mem_loader_if.slave   bus,
  output logic [15:0]         words_loaded_o,
  output logic                done_o,
  output logic                err_o,
  output logic                cpu_rst_n_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          state_q, state_d;
  logic [15:0]     n_q;
  logic [AW-1:0]   idx_q;
  logic [1:0]      cnt_q;
  logic [31:0]     shift_q;
  logic            ready;
  logic            xfer;
  logic            start_load;
  logic            last_word;
  logic [15:0]     n_full;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]      xor_q;
`endif

  assign n_full    = {n_q[15:8], bus.byte_data_i};
  assign last_word = (16'(idx_q) == n_q - 16'd1);
  assign xfer      = ready & bus.byte_valid_i;

  // NOTE: synchronous reset, so rst_i appears only inside the clocked process.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    start_load = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_HDR0;
          start_load = 1'b1;
        end
      end
      S_HDR0: begin
        ready = 1'b1;
        if (bus.byte_valid_i) state_d = S_HDR1;
      end
      S_HDR1: begin
        ready = 1'b1;
        if (bus.byte_valid_i) begin
          if (n_full == 16'd0)             state_d = S_TAIL;
          else if (n_full > 16'(DEPTH))    state_d = S_ERR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        if (bus.byte_valid_i && cnt_q == 2'd3 && last_word) state_d = S_TAIL;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        ready = 1'b1;
        if (bus.byte_valid_i) state_d = (bus.byte_data_i == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready_o = ready;
  assign done_o           = (state_q == S_DONE);
  assign err_o            = (state_q == S_ERR);
  assign cpu_rst_n_o      = (state_q == S_DONE);

  // NOTE: state updates use <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q            <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      shift_q        <= '0;
      words_loaded_o <= '0;
      bus.im_we_o    <= 1'b0;
      bus.im_addr_o  <= '0;
      bus.im_data_o  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      bus.im_we_o <= 1'b0;
      if (start_load) begin
        idx_q          <= '0;
        cnt_q          <= '0;
        shift_q        <= '0;
        words_loaded_o <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        xor_q          <= '0;
`endif
      end
      if (xfer) begin
        unique case (state_q)
          S_HDR0: n_q[15:8] <= bus.byte_data_i;
          S_HDR1: n_q[7:0]  <= bus.byte_data_i;
          S_DATA: begin
            shift_q <= {shift_q[23:0], bus.byte_data_i};
            cnt_q   <= cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q   <= xor_q ^ bus.byte_data_i;
`endif
            // Strobe lands in the cycle after the 4th byte while the next byte is already accepted.
            if (cnt_q == 2'd3) begin
              bus.im_we_o    <= 1'b1;
              bus.im_data_o  <= {shift_q[23:0], bus.byte_data_i};
              bus.im_addr_o  <= {{(30-AW){1'b0}}, idx_q, 2'b00};
              words_loaded_o <= words_loaded_o + 16'd1;
              if (!last_word) idx_q <= idx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader against a stream-level reference model.
module tb_instr_mem_loader;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] words_loaded;
  logic        done, err, cpu_rst_n;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .bus            (bus),
    .words_loaded_o (words_loaded),
    .done_o         (done),
    .err_o          (err),
    .cpu_rst_n_o    (cpu_rst_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  img[$];
  logic [31:0] got_addr[$], got_data[$];
  logic [15:0] got_wl[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;
  int          exp_words;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.im_we_o === 1'b1) begin
      got_addr.push_back(bus.im_addr_o);
      got_data.push_back(bus.im_data_o);
      got_wl.push_back(words_loaded);
    end
  end

  // Reference: interpret the byte image directly from the stream rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = {img[0], img[1]};
    x = 8'h00;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_words = 0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(32'(w * 4));
        exp_data.push_back({img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
        for (int b = 0; b < 4; b++) x = x ^ img[2+4*w+b];
      end
      exp_words = n;
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_done = (img[2+4*n] == x);
      exp_err  = !exp_done;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic append_chk(input bit bad);
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < img.size(); i++) x = x ^ img[i];
    img.push_back(bad ? (x ^ 8'h01) : x);
`endif
  endtask

  task automatic build_rand(input int n, input bit bad);
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    if (n <= DEPTH) begin
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      append_chk(bad);
    end
  endtask

  task automatic build_test1();
    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
  endtask

  task automatic send_bytes(input int count, input int gap_pct);
    int i, cyc;
    bit took;
    i = 0;
    cyc = 0;
    while (i < count && cyc < 4000) begin
      @(negedge clk);
      bus.byte_valid_i = ($urandom_range(99) >= gap_pct);
      bus.byte_data_i  = bus.byte_valid_i ? img[i] : 8'($urandom);
      #1 took = bus.byte_valid_i && bus.byte_ready_o;
      @(posedge clk);
      if (took) i++;
      cyc++;
    end
    #1 bus.byte_valid_i = 1'b0;
    check("send_done", i, count);
    if (gap_pct == 0) check("one_byte_per_cycle", cyc, count);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_load(input bit do_start, input int gap_pct);
    got_addr.delete();
    got_data.delete();
    got_wl.delete();
    model();
    if (do_start) pulse_start();
    send_bytes(img.size(), gap_pct);
    repeat (3) @(negedge clk);
    check("write_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check("im_addr", got_addr[i], exp_addr[i]);
      check("im_data", got_data[i], exp_data[i]);
      check("words_at_strobe", got_wl[i], 32'(i + 1));
    end
    check("words_loaded", words_loaded, exp_words);
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("cpu_rst_n", cpu_rst_n, exp_done);
    check("ready_after", bus.byte_ready_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    check({tag, "_ready"}, bus.byte_ready_o, 1'b0);
    check({tag, "_we"}, bus.im_we_o, 1'b0);
    check({tag, "_words"}, words_loaded, 16'd0);
    check({tag, "_addr"}, bus.im_addr_o, 32'd0);
    check({tag, "_data"}, bus.im_data_o, 32'd0);
  endtask

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Directed two-word image at full rate.
    build_test1();
    append_chk(1'b0);
    run_load(1'b1, 0);

    // Oversized header, then a new start clears err and leaves the loader waiting for a header.
    img = '{8'h00, 8'h21};
    run_load(1'b1, 0);
    pulse_start();
    check("err_cleared", err, 1'b0);
    check("ready_in_hdr", bus.byte_ready_o, 1'b1);

    // Empty image continuing from the header state just entered.
    img = '{8'h00, 8'h00};
    append_chk(1'b0);
    run_load(1'b0, 0);

    // Same two-word image with valid dropping about half the cycles.
    build_test1();
    append_chk(1'b0);
    run_load(1'b1, 50);

    // Reset after the sixth byte: only the first word is written.
    build_test1();
    got_addr.delete();
    got_data.delete();
    got_wl.delete();
    pulse_start();
    send_bytes(6, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_writes", got_addr.size(), 1);
    if (got_addr.size() > 0) begin
      check("midrst_addr", got_addr[0], 32'h0);
      check("midrst_data", got_data[0], 32'hDEADBEEF);
    end

    build_test1();
    append_chk(1'b0);
    run_load(1'b1, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    build_test1();
    append_chk(1'b1);
    run_load(1'b1, 0);
`endif

    // Full-capacity image and randomised loads.
    build_rand(DEPTH, 1'b0);
    run_load(1'b1, 30);
    build_rand($urandom_range(65535, DEPTH + 1), 1'b0);
    run_load(1'b1, 0);
    for (int t = 0; t < 6; t++) begin
      build_rand($urandom_range(8, 1), ($urandom_range(3) == 0));
      run_load(1'b1, (t % 2) * 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
